k2_prog_loader: RTL and testbench

- Writer side of the K2 instruction-memory interface: the CPU fetches 8-bit instructions by PC address; this block fills that memory beforehand.
- Accepts a framed byte stream over a valid/ready handshake, checks it, and writes instructions sequentially from address 0.
- Holds the CPU in reset through `cpu_hold` until a frame loads without error.
- Sits between the board-level byte source (serial/debug bridge) and the program RAM write port.

---
 rtl/k2_loader_pkg.sv | 22 ++
 rtl/k2_prog_loader_if.sv | 29 ++
 rtl/k2_prog_loader.sv | 132 +++++++++++++
 tb/tb_k2_prog_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/k2_loader_pkg.sv
// k2_loader_pkg: shared types and constants for the K2 program loader.
//   state_t        loader FSM states
//   SYNC_BYTE_DEF  default frame start marker
//   ERR_*          err_code values reported on the loader's err_code port
package k2_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;

endpackage

// File: rtl/k2_prog_loader_if.sv
// k2_prog_loader_if: byte-stream input handshake plus program-RAM write port.
//   in_data/in_valid/in_ready  framed byte stream (accept on valid & ready)
//   mem_we/mem_addr/mem_wdata  program memory write port
// Modports:
//   slave  - the loader (consumes the stream, drives the RAM write port)
//   master - the environment (drives the stream, observes the write port)
interface k2_prog_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/k2_prog_loader.sv
// k2_prog_loader: fills K2 program memory from a framed byte stream
// (SYNC, LEN, LEN instruction bytes, CSUM = sum of instructions mod 256)
// and releases the CPU from reset once a frame loads cleanly.
// Ports:
//   clk, reset    clock (rising edge), async active-high reset
//   start         one-cycle pulse; aborts any frame and restarts loading
//   bus           k2_prog_loader_if.slave: byte stream in, RAM write out
//   cpu_hold      1 = CPU held in reset
//   done, error   frame accepted / frame rejected (sticky until start)
//   err_code      ERR_NONE, ERR_LEN (zero length), ERR_CSUM
//   loaded_len    instruction count of the last accepted frame
//
// state   | meaning
// IDLE    | hunting for SYNC_BYTE, other bytes discarded
// LEN     | next byte is the instruction count
// DATA    | writing instruction bytes to memory
// CSUM    | next byte is compared with the running sum
// DONE    | frame loaded, CPU released, stream stalled
// ERR     | frame rejected, CPU held, stream stalled
module k2_prog_loader
  import k2_loader_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] SYNC_BYTE = DATA_W'(SYNC_BYTE_DEF)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  k2_prog_loader_if.slave     bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_code,
  output logic [7:0]          loaded_len
);

  state_t            state_q, state_d;
  logic [7:0]        len_q;
  logic [7:0]        count_q;
  logic [DATA_W-1:0] sum_q;
  logic              accept;
  logic              last_data;
  logic              len_zero;
  logic              csum_ok;

  // Ready is dropped during start so the byte offered in that cycle is
  // left for the restarted frame instead of being swallowed.
  assign bus.in_ready = (state_q inside {ST_IDLE, ST_LEN, ST_DATA, ST_CSUM}) && !start;
  assign accept       = bus.in_valid && bus.in_ready;
  assign last_data    = (count_q == len_q - 8'd1);
  assign len_zero     = (bus.in_data == '0);
  assign csum_ok      = (bus.in_data == sum_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      case (state_q)
        ST_IDLE: if (bus.in_data == SYNC_BYTE) state_d = ST_LEN;
        ST_LEN:  state_d = len_zero ? ST_ERR : ST_DATA;
        ST_DATA: if (last_data) state_d = ST_CSUM;
        ST_CSUM: state_d = csum_ok ? ST_DONE : ST_ERR;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_hold      <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
      err_code      <= ERR_NONE;
      loaded_len    <= 8'd0;
      len_q         <= 8'd0;
      count_q       <= 8'd0;
      sum_q         <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      if (start) begin
        cpu_hold <= 1'b1;
        done     <= 1'b0;
        error    <= 1'b0;
        err_code <= ERR_NONE;
        count_q  <= 8'd0;
        sum_q    <= '0;
      end else if (accept) begin
        case (state_q)
          ST_LEN: begin
            if (len_zero) begin
              error    <= 1'b1;
              err_code <= ERR_LEN;
            end else begin
              len_q   <= 8'(bus.in_data);
              count_q <= 8'd0;
              sum_q   <= '0;
            end
          end
          ST_DATA: begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= ADDR_W'(count_q);
            bus.mem_wdata <= bus.in_data;
            count_q       <= count_q + 8'd1;
            sum_q         <= sum_q + bus.in_data;
          end
          ST_CSUM: begin
            if (csum_ok) begin
              done       <= 1'b1;
              cpu_hold   <= 1'b0;
              loaded_len <= len_q;
            end else begin
              error    <= 1'b1;
              err_code <= ERR_CSUM;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_k2_prog_loader.sv
module tb_k2_prog_loader;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       cpu_hold;
  logic       done;
  logic       error;
  logic [1:0] err_code;
  logic [7:0] loaded_len;

  k2_prog_loader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  k2_prog_loader #(.ADDR_W(8), .DATA_W(8), .SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .loaded_len (loaded_len)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: frame parser over the sequence of accepted bytes.
  // stage 0 = hunting sync, 1 = expecting length, 2 = body (data then csum).
  // fin 0 = frame open, 1 = loaded, 2 = rejected.
  int         stage, fin, mlen;
  logic [7:0] mdata[$];
  logic       exp_we, exp_hold, exp_done, exp_err;
  logic [1:0] exp_code;
  logic [7:0] exp_addr, exp_wdata, exp_ll;
  logic [15:0] wlog[$];

  task automatic model_reset(input bit full);
    stage = 0; fin = 0; mdata.delete();
    exp_we = 0; exp_hold = 1; exp_done = 0; exp_err = 0; exp_code = 0;
    if (full) begin
      exp_addr = 0; exp_wdata = 0; exp_ll = 0;
    end
  endtask

  task automatic model_step(input logic st, input logic acc, input logic [7:0] d);
    int s;
    exp_we = 0;
    if (st) begin
      model_reset(0);
    end else if (acc) begin
      if (stage == 0) begin
        if (d == 8'hA5) stage = 1;
      end else if (stage == 1) begin
        if (d == 0) begin
          fin = 2; exp_err = 1; exp_code = 1;
        end else begin
          mlen = d; mdata.delete(); stage = 2;
        end
      end else if (mdata.size() < mlen) begin
        exp_we = 1; exp_addr = 8'(mdata.size()); exp_wdata = d;
        mdata.push_back(d);
      end else begin
        s = 0;
        foreach (mdata[i]) s += int'(mdata[i]);
        if (d == 8'(s % 256)) begin
          fin = 1; exp_done = 1; exp_hold = 0; exp_ll = 8'(mlen);
        end else begin
          fin = 2; exp_err = 1; exp_code = 2;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("mem_we", bus.mem_we, exp_we);
    check("mem_addr", bus.mem_addr, exp_addr);
    check("mem_wdata", bus.mem_wdata, exp_wdata);
    check("cpu_hold", cpu_hold, exp_hold);
    check("done", done, exp_done);
    check("error", error, exp_err);
    check("err_code", err_code, exp_code);
    check("loaded_len", loaded_len, exp_ll);
    if (bus.mem_we === 1'b1) wlog.push_back({bus.mem_addr, bus.mem_wdata});
  endtask

  // Called just after a falling edge; returns with the next falling edge.
  task automatic cycle(input logic st, input logic v, input logic [7:0] d, output logic acc);
    start = st; bus.in_valid = v; bus.in_data = d;
    #1;
    check("in_ready", bus.in_ready, (fin == 0) && !st);
    acc = v && (fin == 0) && !st;
    @(posedge clk);
    model_step(st, acc, d);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send(input bq_t b, input int vpct);
    logic acc;
    int   tries;
    foreach (b[i]) begin
      acc = 0; tries = 0;
      while (!acc && tries < 64 && fin == 0) begin
        cycle(1'b0, ($urandom_range(99) < vpct), b[i], acc);
        tries++;
      end
    end
    start = 0; bus.in_valid = 0;
  endtask

  task automatic pulse_start();
    logic acc;
    cycle(1'b1, 1'($urandom_range(1)), 8'($urandom), acc);
    start = 0; bus.in_valid = 0;
  endtask

  task automatic idle(input int n);
    logic acc;
    repeat (n) cycle(1'b0, 1'b0, 8'h00, acc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic acc;
    bq_t  fr;
    int   len, vpct, ngarb;
    logic [7:0] cs, g;

    reset = 1; start = 0; bus.in_valid = 0; bus.in_data = 0;
    model_reset(1);
    repeat (2) @(negedge clk);
    check_outputs();
    check("rst_in_ready", bus.in_ready, 1);
    reset = 0;

    // Normal 3-instruction frame
    wlog.delete();
    send('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66}, 100);
    idle(1);
    check("t1_nwrites", wlog.size(), 3);
    if (wlog.size() == 3) begin
      check("t1_w0", wlog[0], 16'h0011);
      check("t1_w1", wlog[1], 16'h0122);
      check("t1_w2", wlog[2], 16'h0233);
    end
    check("t1_done", done, 1);
    check("t1_hold", cpu_hold, 0);
    check("t1_len", loaded_len, 3);
    check("t1_err", error, 0);

    // Garbage before sync
    pulse_start();
    wlog.delete();
    send('{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7F, 8'h7F}, 100);
    check("t2_nwrites", wlog.size(), 1);
    if (wlog.size() == 1) check("t2_w0", wlog[0], 16'h007F);
    check("t2_done", done, 1);
    check("t2_len", loaded_len, 1);

    // Checksum mismatch
    pulse_start();
    send('{8'hA5, 8'h02, 8'h80, 8'h90, 8'h11}, 100);
    cycle(1'b0, 1'b1, 8'hA5, acc);
    check("t3_ready", bus.in_ready, 0);
    check("t3_err", error, 1);
    check("t3_code", err_code, 2);
    check("t3_hold", cpu_hold, 1);
    check("t3_done", done, 0);
    check("t3_len_kept", loaded_len, 1);
    pulse_start();
    #1;
    check("t3_err_clr", error, 0);
    check("t3_ready_back", bus.in_ready, 1);
    @(negedge clk);
    check_outputs();

    // Zero length
    wlog.delete();
    send('{8'hA5, 8'h00}, 100);
    idle(2);
    check("t4_err", error, 1);
    check("t4_code", err_code, 1);
    check("t4_nwrites", wlog.size(), 0);

    // Start coincident with a valid byte mid-frame
    pulse_start();
    send('{8'hA5, 8'h04, 8'h01}, 100);
    cycle(1'b1, 1'b1, 8'h07, acc);
    check("t5_ready_in_start", bus.in_ready, 0);
    start = 0;
    wlog.delete();
    send('{8'hA5, 8'h01, 8'h05, 8'h05}, 100);
    check("t5_nwrites", wlog.size(), 1);
    if (wlog.size() == 1) check("t5_w0", wlog[0], 16'h0005);
    check("t5_done", done, 1);

    // Asynchronous reset during DATA
    pulse_start();
    send('{8'hA5, 8'h04, 8'h01, 8'h02}, 100);
    reset = 1;
    #1;
    model_reset(1);
    check_outputs();
    check("t6_hold", cpu_hold, 1);
    @(negedge clk);
    reset = 0;
    wlog.delete();
    send('{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A}, 70);
    check("t6_done", done, 1);
    check("t6_len", loaded_len, 4);
    check("t6_nwrites", wlog.size(), 4);

    // Randomized frames; the first is a full-length back-to-back frame
    for (int it = 0; it < 40; it++) begin
      pulse_start();
      fr = {};
      ngarb = $urandom_range(3);
      for (int k = 0; k < ngarb; k++) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        fr.push_back(g);
      end
      fr.push_back(8'hA5);
      len = (it == 0) ? 255 : (($urandom_range(9) == 0) ? 0 : $urandom_range(1, 12));
      fr.push_back(8'(len));
      cs = 0;
      for (int k = 0; k < len; k++) begin
        g = ($urandom_range(7) == 0) ? 8'hA5 : 8'($urandom);
        fr.push_back(g);
        cs += g;
      end
      if ($urandom_range(4) == 0) cs ^= 8'($urandom_range(1, 255));
      fr.push_back(cs);
      if (it != 0 && $urandom_range(9) == 0) fr = fr[0:$urandom_range(fr.size() - 1)];
      vpct = (it == 0) ? 100 : $urandom_range(50, 100);
      send(fr, vpct);
      idle($urandom_range(2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
